// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, FSM state type and digit adjust helper for the BCD converter
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [DIGIT_W-1:0] add3_adjust(input logic [DIGIT_W-1:0] digit);
    return (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// rtl/bcd_dabble_digit.sv - combinational add-3 correction for one BCD digit
module bcd_dabble_digit
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = add3_adjust(digit_i);

endmodule

// File: rtl/bcd_converter_seq.sv
// rtl/bcd_converter_seq.sv - sequential double-dabble binary-to-BCD converter with handshake, saturation and blanking
module bcd_converter_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4,
  parameter int AUTO   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      out_valid,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      overflow,
  output logic [DIGITS-1:0]         blank
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
  localparam logic [BCD_W-1:0]  ALL_NINES = {DIGITS{4'h9}};

  state_e state_q, state_d;

  logic [SH_W-1:0]   shreg_q, shreg_adj, shreg_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic [BIN_W-1:0]  last_bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic              overflow_q;
  logic [DIGITS-1:0] blank_q;

  logic              start;
  logic              last_shift;
  logic              ovf_d;
  logic [BCD_W-1:0]  bcd_d;
  logic [DIGITS-1:0] blank_d;

  // Digits sit above the binary part; the binary bits pass through unadjusted.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_dabble_digit u_digit (
      .digit_i (shreg_q[BIN_W + DIGIT_W*k +: DIGIT_W]),
      .digit_o (shreg_adj[BIN_W + DIGIT_W*k +: DIGIT_W])
    );
  end
  assign shreg_adj[BIN_W-1:0] = shreg_q[BIN_W-1:0];

  assign shreg_d    = {shreg_adj[SH_W-2:0], 1'b0};
  assign ovf_d      = ovf_q | shreg_adj[SH_W-1];
  assign bcd_d      = shreg_d[SH_W-1 -: BCD_W];
  assign last_shift = (cnt_q == CNT_LAST);
  assign start      = (AUTO != 0) ? (bin_in != last_bin_q) : in_valid;

  always_comb begin
    logic zero_above;
    blank_d    = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (bcd_d[DIGIT_W*k +: DIGIT_W] == '0);
      blank_d[k] = zero_above & ~ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Results are captured on the final shift so they are visible during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q    <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      last_bin_q <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      blank_q    <= BLANK_RST;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q    <= {{BCD_W{1'b0}}, bin_in};
            last_bin_q <= bin_in;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
          end
        end
        SHIFT: begin
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          ovf_q   <= ovf_d;
          if (last_shift) begin
            bcd_q      <= ovf_d ? ALL_NINES : bcd_d;
            overflow_q <= ovf_d;
            blank_q    <= blank_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = overflow_q;
  assign blank    = blank_q;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// tb/tb_bcd_converter_seq.sv - directed table-driven bench for the BCD converter (handshake and auto modes)
module tb_bcd_converter_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, overflow;
  logic [13:0] bin_in;
  logic [15:0] bcd_out;
  logic [3:0]  blank;

  logic        in_valid_a, in_ready_a, out_valid_a, overflow_a;
  logic [6:0]  bin_a;
  logic [7:0]  bcd_a;
  logic [1:0]  blank_a;

  bcd_converter_seq #(.BIN_W(14), .DIGITS(4), .AUTO(0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .bcd_out   (bcd_out),
    .overflow  (overflow),
    .blank     (blank)
  );

  bcd_converter_seq #(.BIN_W(7), .DIGITS(2), .AUTO(1)) u_dut_auto (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .bin_in    (bin_a),
    .out_valid (out_valid_a),
    .bcd_out   (bcd_a),
    .overflow  (overflow_a),
    .blank     (blank_a)
  );

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blk;
  } vec_t;

  vec_t vecs[9];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge while the main DUT is idle; returns cycles from accept to out_valid.
  task automatic run_main(input logic [13:0] b, output int n);
    in_valid = 1'b1;
    bin_in   = b;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, p, rdy_hi;
    bit seen;

    vecs[0] = '{14'd9999,  16'h9999, 1'b0, 4'b0000};
    vecs[1] = '{14'd10000, 16'h9999, 1'b1, 4'b0000};
    vecs[2] = '{14'd16383, 16'h9999, 1'b1, 4'b0000};
    vecs[3] = '{14'd0,     16'h0000, 1'b0, 4'b1110};
    vecs[4] = '{14'd105,   16'h0105, 1'b0, 4'b1000};
    vecs[5] = '{14'd1234,  16'h1234, 1'b0, 4'b0000};
    vecs[6] = '{14'd7,     16'h0007, 1'b0, 4'b1110};
    vecs[7] = '{14'd50,    16'h0050, 1'b0, 4'b1100};
    vecs[8] = '{14'd999,   16'h0999, 1'b0, 4'b1000};

    rst        = 1'b1;
    in_valid   = 1'b0;
    bin_in     = '0;
    in_valid_a = 1'b0;
    bin_a      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset bcd_out", bcd_out, 0);
    chk("reset overflow", overflow, 0);
    chk("reset blank", blank, 4'b1110);
    chk("reset auto bcd", bcd_a, 0);
    chk("reset auto blank", blank_a, 2'b10);

    for (int i = 0; i < 9; i++) begin
      run_main(vecs[i].bin, n);
      chk($sformatf("vec%0d latency", i), n, 15);
      chk($sformatf("vec%0d bcd", i), bcd_out, vecs[i].bcd);
      chk($sformatf("vec%0d overflow", i), overflow, vecs[i].ovf);
      chk($sformatf("vec%0d blank", i), blank, vecs[i].blk);
      @(negedge clk);
      chk($sformatf("vec%0d pulse width", i), out_valid, 0);
      chk($sformatf("vec%0d bcd hold", i), bcd_out, vecs[i].bcd);
    end

    // Back-to-back conversions with in_valid held high throughout.
    in_valid = 1'b1;
    bin_in   = 14'd1234;
    n = 0;
    rdy_hi = 0;
    do begin
      @(negedge clk);
      n++;
      if (in_ready) rdy_hi++;
    end while (!out_valid && n < 100);
    chk("b2b first latency", n, 15);
    chk("b2b first bcd", bcd_out, 16'h1234);
    bin_in = 14'd5678;
    p = n;
    do begin
      @(negedge clk);
      n++;
      if (in_ready) rdy_hi++;
    end while (!out_valid && n < 200);
    in_valid = 1'b0;
    chk("b2b pulse spacing", n - p, 16);
    chk("b2b second bcd", bcd_out, 16'h5678);
    chk("b2b ready cycles", rdy_hi, 1);
    repeat (2) @(negedge clk);
    chk("b2b no extra start", in_ready, 1);

    // Reset in the middle of a conversion.
    in_valid = 1'b1;
    bin_in   = 14'd4321;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort busy before rst", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort in_ready", in_ready, 1);
    chk("abort out_valid", out_valid, 0);
    chk("abort bcd_out", bcd_out, 0);
    chk("abort overflow", overflow, 0);
    chk("abort blank", blank, 4'b1110);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort no out_valid", seen, 0);

    // Auto mode: steady zero stays quiet, then a change mid-conversion is picked up next.
    chk("auto idle bcd", bcd_a, 0);
    chk("auto idle out_valid", out_valid_a, 0);
    bin_a = 7'd42;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 3) bin_a = 7'd43;
    end while (!out_valid_a && n < 100);
    chk("auto first latency", n, 8);
    chk("auto first bcd", bcd_a, 8'h42);
    chk("auto first overflow", overflow_a, 0);
    chk("auto first blank", blank_a, 2'b00);
    p = n;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_a && n < 200);
    chk("auto second spacing", n - p, 9);
    chk("auto second bcd", bcd_a, 8'h43);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid_a) seen = 1'b1;
    end
    chk("auto steady no out_valid", seen, 0);
    chk("auto steady bcd hold", bcd_a, 8'h43);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
